reg_save_sequencer: RTL

- Hardware initiator for the CPU stack: pushes r1..r(NREGS) onto the stack on interrupt entry and pops them back into the register file on interrupt return.
- Sits between the interrupt controller (start pulses), the register file (second read port plus a write port) and the stack (push/pop/d/q).
- Replaces the software push/pop prologue and epilogue in interrupt handlers.

---
 rtl/fpgc_pkg.sv | 8 +
 rtl/reg_save_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/fpgc_pkg.sv
// fpgc_pkg: shared state enum and default sizing for the register save sequencer
package fpgc_pkg;
  localparam int NREGS = 15;
  localparam int STACK_DEPTH = 128;
  localparam int MAXF = STACK_DEPTH / NREGS;
  localparam int ADDR_W = 4;
  typedef enum logic [2:0] {IDLE, SAVE, SAVE_LAST, REST, REST_LAST, FINISH} state_t;
endpackage

// File: rtl/reg_save_sequencer.sv
// reg_save_sequencer: pushes r1..rNREGS to the stack on save_start and pops them back on restore_start (ports: start/hold control, busy/done/err status, register-file read/write, stack push/pop)
module reg_save_sequencer #(
  parameter int NREGS = fpgc_pkg::NREGS,
  parameter int DATA_W = 32,
  parameter int ADDR_W = fpgc_pkg::ADDR_W,
  parameter int STACK_DEPTH = fpgc_pkg::STACK_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_start,
  input  logic              restore_start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_d,
  input  logic [DATA_W-1:0] stk_q
);
  import fpgc_pkg::*;
  localparam int MAXF = STACK_DEPTH / NREGS;
  localparam int FW = $clog2(MAXF + 1);
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic [FW-1:0] frames;
  logic dir_save, err_r, hp, last;
  logic [DATA_W-1:0] sav;
  assign last = idx == ADDR_W'(NREGS);
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      frames <= '0;
      dir_save <= 1'b0;
      err_r <= 1'b0;
      hp <= 1'b0;
      sav <= '0;
    end else begin
      err_r <= 1'b0;
      hp <= hold && state != IDLE;
      if (hold && !hp && state != IDLE) sav <= rf_rdata;
      if (!hold)
        case (state)
          IDLE:
            if (save_start) begin
              if (frames == FW'(MAXF)) err_r <= 1'b1;
              else begin
                state <= SAVE;
                idx <= ADDR_W'(1);
                dir_save <= 1'b1;
              end
            end else if (restore_start) begin
              if (frames == '0) err_r <= 1'b1;
              else begin
                state <= REST;
                idx <= ADDR_W'(1);
                dir_save <= 1'b0;
              end
            end
          SAVE: begin
            state <= last ? SAVE_LAST : SAVE;
            idx <= last ? idx : idx + ADDR_W'(1);
          end
          SAVE_LAST: state <= FINISH;
          REST: begin
            state <= last ? REST_LAST : REST;
            idx <= last ? idx : idx + ADDR_W'(1);
          end
          REST_LAST: state <= FINISH;
          FINISH: begin
            state <= IDLE;
            idx <= '0;
            frames <= dir_save ? frames + FW'(1) : frames - FW'(1);
          end
          default: state <= IDLE;
        endcase
    end
  assign busy = state inside {SAVE, SAVE_LAST, REST, REST_LAST};
  assign done = state == FINISH && !hold;
  assign err = err_r;
  assign stk_push = !hold && ((state == SAVE && idx != ADDR_W'(1)) || state == SAVE_LAST);
  assign stk_pop = !hold && state == REST;
  assign rf_we = !hold && ((state == REST && idx != ADDR_W'(1)) || state == REST_LAST);
  assign rf_raddr = state == SAVE ? idx : '0;
  assign rf_waddr = !rf_we ? '0 : state == REST_LAST ? ADDR_W'(1) : ADDR_W'(NREGS + 2) - idx;
  assign stk_d = stk_push ? (hp ? sav : rf_rdata) : '0;
  assign rf_wdata = rf_we ? stk_q : '0;
endmodule
